// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state enum, writeback status codes, status register index,
// default watchdog limit and a helper that picks the status code by op kind.
package multdiv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    WRITE = 2'd3
  } md_state_t;

  localparam logic [31:0] STATUS_MUL  = 32'd4;
  localparam logic [31:0] STATUS_DIV  = 32'd5;
  localparam logic [4:0]  REG_RSTATUS = 5'd30;

  localparam int DEFAULT_TIMEOUT_CYCLES = 40;

  function automatic logic [31:0] status_code(input logic is_div);
    return is_div ? STATUS_DIV : STATUS_MUL;
  endfunction

endpackage

// File: rtl/multdiv_watchdog.sv
// WAIT-cycle watchdog for the multiply/divide sequencer.
// Latency: timeout is combinational on the TIMEOUT_CYCLES-th counted cycle.
// Backpressure: none; counts whenever count_en is high.
//
// Ports: clock/reset (sync, active-high); clear restarts the count (operation
// accepted); count_en is high in every WAIT cycle; timeout flags the last
// allowed WAIT cycle so the sequencer leaves WAIT at the end of it.
module multdiv_watchdog #(
  parameter int TIMEOUT_CYCLES = multdiv_pkg::DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic timeout
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wait_cnt;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      wait_cnt <= '0;
    end else if (count_en) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // The count holds the number of WAIT cycles already completed, so the
  // cycle in which it equals TIMEOUT_CYCLES-1 is the final permitted one.
  assign timeout = count_en && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/multdiv_sequencer.sv
// Sequences the shared multi-cycle mul/div unit and issues one writeback.
// Latency: accept -> start pulse +1, md_ready -> writeback +1 (min 3 total).
// Backpressure: holds stall high from accept through WAIT; WAIT waits on md_ready.
//
// Ports: clock/reset (sync, active-high); dx_* decoded instruction and
// bypassed operands from D/X; md_* unit handshake; ctrl_MULT/ctrl_DIV start
// pulses; md_opA/md_opB latched operands; stall/busy/busy_rd to the pipeline;
// wb_valid/wb_reg/wb_data single-cycle register writeback.
// Optional feature: define MULTDIV_TIMEOUT_EN to bound WAIT by TIMEOUT_CYCLES.
module multdiv_sequencer
  import multdiv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        dx_valid,
  input  logic        dx_mul,
  input  logic        dx_div,
  input  logic [4:0]  dx_rd,
  input  logic [31:0] dx_opA,
  input  logic [31:0] dx_opB,
  input  logic        md_ready,
  input  logic        md_exception,
  input  logic [31:0] md_result,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic [31:0] md_opA,
  output logic [31:0] md_opB,
  output logic        stall,
  output logic        busy,
  output logic [4:0]  busy_rd,
  output logic        wb_valid,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data
);

  md_state_t   state;
  md_state_t   state_nxt;

  logic        start_req;
  logic        accept;
  logic        finish;
  logic        timeout;

  logic [31:0] op_a_q;
  logic [31:0] op_b_q;
  logic        kind_div_q;
  logic [4:0]  rd_q;
  logic [31:0] result_q;
  logic        exc_q;

  assign start_req = dx_valid && (dx_mul || dx_div);
  assign accept    = (state == IDLE) && start_req;
  assign finish    = (state == WAIT) && (md_ready || timeout);

`ifdef MULTDIV_TIMEOUT_EN
  multdiv_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .clear   (accept),
    .count_en(state == WAIT),
    .timeout (timeout)
  );
`else
  logic unused_timeout_param;
  assign unused_timeout_param = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_req) state_nxt = START;
      START:   state_nxt = WAIT;
      WAIT:    if (md_ready || timeout) state_nxt = WRITE;
      WRITE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand / result capture
  always_ff @(posedge clock) begin
    if (reset) begin
      op_a_q     <= '0;
      op_b_q     <= '0;
      kind_div_q <= 1'b0;
      rd_q       <= '0;
      result_q   <= '0;
      exc_q      <= 1'b0;
    end else begin
      if (accept) begin
        op_a_q     <= dx_opA;
        op_b_q     <= dx_opB;
        kind_div_q <= !dx_mul;  // mul wins when both flags are set
        rd_q       <= dx_rd;
      end
      if (finish) begin
        result_q <= md_result;
        // md_ready takes priority over a coincident timeout; a timeout
        // alone always takes the exception path.
        exc_q    <= md_ready ? md_exception : 1'b1;
      end
    end
  end

  // Output logic
  always_comb begin
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    stall     = 1'b0;
    busy      = 1'b0;
    busy_rd   = '0;
    wb_valid  = 1'b0;
    wb_reg    = '0;
    wb_data   = '0;
    md_opA    = op_a_q;
    md_opB    = op_b_q;
    case (state)
      IDLE: begin
        stall = start_req;
      end
      START: begin
        ctrl_MULT = !kind_div_q;
        ctrl_DIV  = kind_div_q;
        stall     = 1'b1;
        busy      = 1'b1;
        busy_rd   = rd_q;
      end
      WAIT: begin
        stall   = 1'b1;
        busy    = 1'b1;
        busy_rd = rd_q;
      end
      WRITE: begin
        busy    = 1'b1;
        busy_rd = rd_q;
        if (exc_q) begin
          wb_valid = 1'b1;
          wb_reg   = REG_RSTATUS;
          wb_data  = status_code(kind_div_q);
        end else begin
          wb_valid = (rd_q != 5'd0);
          wb_reg   = rd_q;
          wb_data  = result_q;
        end
      end
      default: begin
        stall = 1'b0;
      end
    endcase
  end

endmodule
